// File: rtl/heap_access_arbiter.sv
// heap_access_arbiter: round-robin arbiter sequencing shared heapMemory accesses
// through a three-cycle heapClock strobe with one-hot grant and response pulses.
module heap_access_arbiter #(
    parameter int NReq = 4,
    parameter int MemoryElementWidth = 12,
    parameter int NHeap = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NReq-1:0]                    reqValid,
    input  logic [NReq-1:0]                    reqWrite,
    input  logic [NReq*NHeap-1:0]              reqAddress,
    input  logic [NReq*MemoryElementWidth-1:0] reqIn,
    output logic [NReq-1:0]                    reqReady,
    output logic [NReq-1:0]                    respValid,
    output logic [MemoryElementWidth-1:0]      respData,
    output logic                               busy,
    output logic                               heapClock,
    output logic                               heapWrite,
    output logic [NHeap-1:0]                   heapAddress,
    output logic [MemoryElementWidth-1:0]      heapIn,
    input  logic [MemoryElementWidth-1:0]      heapOut
);
    localparam int PW = $clog2(NReq);

    typedef enum logic [1:0] {IDLE, STROBE, RELEASE} state_t;

    state_t state, state_next;
    logic [PW-1:0] ptr, win, granted, jj;
    logic any;
    int j;
    logic [NHeap-1:0] addr_a [NReq];
    logic [MemoryElementWidth-1:0] in_a [NReq];

    for (genvar r = 0; r < NReq; r++) begin : g_unpack
        assign addr_a[r] = reqAddress[r*NHeap +: NHeap];
        assign in_a[r] = reqIn[r*MemoryElementWidth +: MemoryElementWidth];
    end

    // Scan from the far end of the search order so the first valid after ptr wins.
    always_comb begin
        any = 1'b0;
        win = ptr;
        j = 0;
        jj = '0;
        for (int i = NReq - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NReq) j = j - NReq;
            jj = PW'(j);
            if (reqValid[jj]) begin
                any = 1'b1;
                win = jj;
            end
        end
    end

    always_comb begin
        state_next = state == IDLE ? (any ? STROBE : IDLE) : state == STROBE ? RELEASE : IDLE;
    end

    assign busy = state != IDLE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            granted <= '0;
            heapClock <= 1'b0;
            heapWrite <= 1'b0;
            heapAddress <= '0;
            heapIn <= '0;
            reqReady <= '0;
            respValid <= '0;
            respData <= '0;
        end else begin
            heapClock <= 1'b0;
            reqReady <= '0;
            respValid <= '0;
            if (state == IDLE && any) begin
                heapAddress <= addr_a[win];
                heapIn <= in_a[win];
                heapWrite <= reqWrite[win];
                heapClock <= 1'b1;
                reqReady <= NReq'(1) << win;
                ptr <= win == PW'(NReq - 1) ? '0 : win + 1'b1;
                granted <= win;
            end
            if (state == RELEASE) begin
                respData <= heapOut;
                respValid <= NReq'(1) << granted;
            end
        end
    end
endmodule

// File: tb/tb_heap_access_arbiter.sv
// tb_heap_access_arbiter: directed scenarios against a behavioural heapMemory
// that stores on heapClock rise and echoes written data.
module tb_heap_access_arbiter;
    logic clock;
    logic reset;
    logic [3:0] reqValid, reqWrite, reqReady, respValid;
    logic [15:0] reqAddress;
    logic [47:0] reqIn;
    logic [11:0] respData, heapIn, heapOut;
    logic busy, heapClock, heapWrite;
    logic [3:0] heapAddress;
    logic [11:0] mem [16];
    logic [3:0] exp_v;
    int errors = 0;
    int checks = 0;

    heap_access_arbiter dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqWrite(reqWrite),
        .reqAddress(reqAddress), .reqIn(reqIn), .reqReady(reqReady), .respValid(respValid),
        .respData(respData), .busy(busy), .heapClock(heapClock), .heapWrite(heapWrite),
        .heapAddress(heapAddress), .heapIn(heapIn), .heapOut(heapOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 12'(100 + i);
        heapOut = '0;
        forever begin
            @(posedge heapClock);
            #1;
            if (heapWrite) begin
                mem[heapAddress] = heapIn;
                heapOut = heapIn;
            end else heapOut = mem[heapAddress];
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int r, input logic w, input logic [3:0] a, input logic [11:0] d);
        reqWrite[r] = w;
        reqAddress[r*4 +: 4] = a;
        reqIn[r*12 +: 12] = d;
        reqValid[r] = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        reqValid = '0; reqWrite = '0; reqAddress = '0; reqIn = '0;
        #1 reset = 1'b0;
        tick; tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (heapClock !== 1'b0) begin errors++; $display("FAIL rst_hclk got=%b exp=0", heapClock); end
        checks++; if (heapWrite !== 1'b0) begin errors++; $display("FAIL rst_hwr got=%b exp=0", heapWrite); end
        checks++; if (reqReady !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", reqReady); end
        checks++; if (respValid !== 4'b0000) begin errors++; $display("FAIL rst_resp got=%b exp=0000", respValid); end
        checks++; if (heapAddress !== 4'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", heapAddress); end
        checks++; if (heapIn !== 12'd0) begin errors++; $display("FAIL rst_hin got=%0d exp=0", heapIn); end
        checks++; if (respData !== 12'd0) begin errors++; $display("FAIL rst_rdata got=%0d exp=0", respData); end
        reset = 1'b1;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_rel_busy got=%b exp=0", busy); end
    endtask

    task automatic test_all_simultaneous;
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 4'(k), 12'd0);
        for (int k = 0; k < 4; k++) begin
            exp_v = 4'(1) << k;
            tick;
            checks++; if (reqReady !== exp_v) begin errors++; $display("FAIL all_grant%0d got=%b exp=%b", k, reqReady, exp_v); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all_busy_s%0d got=%b exp=1", k, busy); end
            reqValid[k] = 1'b0;
            tick;
            checks++; if (busy !== 1'b1 || reqReady !== 4'b0000) begin errors++; $display("FAIL all_release%0d busy=%b ready=%b exp busy=1 ready=0000", k, busy, reqReady); end
            tick;
            checks++; if (respValid !== exp_v) begin errors++; $display("FAIL all_resp%0d got=%b exp=%b", k, respValid, exp_v); end
            checks++; if (respData !== 12'(100 + k)) begin errors++; $display("FAIL all_data%0d got=%0d exp=%0d", k, respData, 100 + k); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all_idle%0d got=%b exp=0", k, busy); end
        end
        tick;
        checks++; if (respValid !== 4'b0000 || reqReady !== 4'b0000) begin errors++; $display("FAIL all_end resp=%b ready=%b exp=0000", respValid, reqReady); end
    endtask

    task automatic test_write_read;
        set_req(2, 1'b1, 4'd3, 12'd25);
        tick;
        checks++; if (reqReady !== 4'b0100) begin errors++; $display("FAIL wr_ready got=%b exp=0100", reqReady); end
        checks++; if (heapClock !== 1'b1) begin errors++; $display("FAIL wr_hclk got=%b exp=1", heapClock); end
        checks++; if (heapWrite !== 1'b1) begin errors++; $display("FAIL wr_hwr got=%b exp=1", heapWrite); end
        checks++; if (heapAddress !== 4'd3) begin errors++; $display("FAIL wr_addr got=%0d exp=3", heapAddress); end
        checks++; if (heapIn !== 12'd25) begin errors++; $display("FAIL wr_hin got=%0d exp=25", heapIn); end
        reqValid = '0;
        tick;
        checks++; if (reqReady !== 4'b0000 || heapClock !== 1'b0) begin errors++; $display("FAIL wr_strobe ready=%b hclk=%b exp 0000/0", reqReady, heapClock); end
        checks++; if (respValid !== 4'b0000) begin errors++; $display("FAIL wr_early_resp got=%b exp=0000", respValid); end
        tick;
        checks++; if (respValid !== 4'b0100) begin errors++; $display("FAIL wr_resp got=%b exp=0100", respValid); end
        checks++; if (respData !== 12'd25) begin errors++; $display("FAIL wr_echo got=%0d exp=25", respData); end
        tick;
        checks++; if (respValid !== 4'b0000) begin errors++; $display("FAIL wr_resp_clear got=%b exp=0000", respValid); end
        set_req(0, 1'b0, 4'd3, 12'd0);
        tick;
        checks++; if (reqReady !== 4'b0001 || heapWrite !== 1'b0) begin errors++; $display("FAIL rd_ready got=%b hwr=%b exp=0001/0", reqReady, heapWrite); end
        reqValid = '0;
        tick; tick;
        checks++; if (respValid !== 4'b0001) begin errors++; $display("FAIL rd_resp got=%b exp=0001", respValid); end
        checks++; if (respData !== 12'd25) begin errors++; $display("FAIL rd_data got=%0d exp=25", respData); end
        tick;
    endtask

    task automatic test_wrap;
        set_req(2, 1'b0, 4'd2, 12'd0);
        tick;
        checks++; if (reqReady !== 4'b0100) begin errors++; $display("FAIL wrap_pre got=%b exp=0100", reqReady); end
        reqValid = '0;
        tick; tick;
        set_req(0, 1'b0, 4'd5, 12'd0);
        set_req(3, 1'b0, 4'd6, 12'd0);
        tick;
        checks++; if (reqReady !== 4'b1000) begin errors++; $display("FAIL wrap_first got=%b exp=1000", reqReady); end
        reqValid[3] = 1'b0;
        tick; tick;
        checks++; if (respValid !== 4'b1000 || respData !== 12'd106) begin errors++; $display("FAIL wrap_resp3 got=%b/%0d exp=1000/106", respValid, respData); end
        tick;
        checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL wrap_second got=%b exp=0001", reqReady); end
        reqValid[0] = 1'b0;
        tick; tick;
        checks++; if (respValid !== 4'b0001 || respData !== 12'd105) begin errors++; $display("FAIL wrap_resp0 got=%b/%0d exp=0001/105", respValid, respData); end
        tick;
    endtask

    task automatic test_fairness;
        set_req(1, 1'b0, 4'd1, 12'd0);
        set_req(2, 1'b0, 4'd2, 12'd0);
        for (int k = 0; k < 4; k++) begin
            exp_v = (k % 2) ? 4'b0100 : 4'b0010;
            tick;
            checks++; if (reqReady !== exp_v) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", k, reqReady, exp_v); end
            if (k == 3) reqValid = '0;
            tick; tick;
        end
        tick;
        checks++; if (reqReady !== 4'b0000) begin errors++; $display("FAIL fair_end got=%b exp=0000", reqReady); end
    endtask

    task automatic test_idle;
        for (int k = 0; k < 20; k++) begin
            tick;
            checks++; if (heapClock !== 1'b0 || busy !== 1'b0 || reqReady !== 4'b0000) begin errors++; $display("FAIL idle%0d hclk=%b busy=%b ready=%b exp 0/0/0000", k, heapClock, busy, reqReady); end
        end
        set_req(2, 1'b0, 4'd2, 12'd0);
        set_req(3, 1'b0, 4'd3, 12'd0);
        tick;
        checks++; if (reqReady !== 4'b1000) begin errors++; $display("FAIL idle_ptr got=%b exp=1000", reqReady); end
        reqValid[3] = 1'b0;
        tick; tick; tick;
        checks++; if (reqReady !== 4'b0100) begin errors++; $display("FAIL idle_next got=%b exp=0100", reqReady); end
        reqValid = '0;
        tick; tick; tick;
    endtask

    task automatic test_reset_mid;
        set_req(0, 1'b1, 4'd1, 12'd10);
        tick;
        checks++; if (heapClock !== 1'b1) begin errors++; $display("FAIL mid_hclk_pre got=%b exp=1", heapClock); end
        reqValid = '0;
        #3 reset = 1'b0;
        #1;
        checks++; if (heapClock !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_drop hclk=%b busy=%b exp 0/0", heapClock, busy); end
        checks++; if (heapAddress !== 4'd0 || heapIn !== 12'd0 || heapWrite !== 1'b0) begin errors++; $display("FAIL mid_bus addr=%0d in=%0d wr=%b exp 0/0/0", heapAddress, heapIn, heapWrite); end
        checks++; if (reqReady !== 4'b0000) begin errors++; $display("FAIL mid_ready got=%b exp=0000", reqReady); end
        tick;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (respValid !== 4'b0000) begin errors++; $display("FAIL mid_noresp%0d got=%b exp=0000", k, respValid); end
        end
        set_req(0, 1'b0, 4'd1, 12'd0);
        tick;
        checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL mid_rd_ready got=%b exp=0001", reqReady); end
        reqValid = '0;
        tick; tick;
        checks++; if (respValid !== 4'b0001 || respData !== 12'd10) begin errors++; $display("FAIL mid_rd_data got=%b/%0d exp=0001/10", respValid, respData); end
        tick;
    endtask

    initial begin
        test_reset;
        test_all_simultaneous;
        test_write_read;
        test_wrap;
        test_fairness;
        test_idle;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
